id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the five-stage MIPS pipeline. It captures the two operands read from the register file, the decoded immediate and control bits into the ID/EX pipeline register. It detects load-use hazards and inserts bubbles, and applies branch flushes. It also precomputes registered forwarding selects for the EX-stage ALU operand muxes and keeps a saturating stall-cycle counter.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register numbers).
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  32  PC of ID instruction.
- id_rs, id_rt, id_rd  input  5 each  register fields of ID instruction.
- id_uses_rt  input  1  ID instruction reads rt as a source (R-type, store, beq/bne).
- id_rs_data, id_rt_data  input  32 each  register file read ports 1 and 2.
- id_imm  input  32  sign/zero-extended immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded controls.
- id_alu_op  input  4  ALU operation.
- flush  input  1  branch/jump resolved taken in EX; ID instruction is wrong-path.
- mem_reg_write  input  1  instruction currently in MEM writes a register.
- mem_dest  input  5  destination register of instruction in MEM.
- stall  output  1  combinational load-use stall request.
- pc_write_en, ifid_write_en  output  1 each  combinational, equal to ~stall.
- ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt  output  1/32/32/32/32/5/5  registered ID/EX fields.
- ex_dest  output  5  registered destination: id_reg_dst ? id_rd : id_rt.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each  registered controls.
- ex_alu_op  output  4  registered ALU op.
- ex_fwd_a, ex_fwd_b  output  2 each  registered forwarding selects: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
- stall_count  output  16  saturating count of stall cycles.

## Operation
- Hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)) & ~flush.
- Posedge capture priority:
  - flush: bubble.
  - else stall: bubble.
  - else: load all ID fields; ex_valid = id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg cleared. Data fields, ex_dest and ex_alu_op are don't-care but are held at previous values (no toggling).
- Forward A (on a load, using id_rs):
  - 10 if ex_valid & ex_reg_write & ex_dest != 0 & ex_dest == id_rs;
  - else 01 if mem_reg_write & mem_dest != 0 & mem_dest == id_rs;
  - else 00.
  - EX/MEM wins when both match.
- Forward B: same rules using id_rt. Computed regardless of id_uses_rt; the consumer ignores it when ex_alu_src selects the immediate.
- Register 0 never forwards.
- No WB bypass in this block. The register file writes on negedge, so a WB-stage write is already visible to the posedge sample.
- stall_count increments on each posedge where stall = 1 and saturates at 16'hFFFF.

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing posedge.
- stall, pc_write_en and ifid_write_en are combinational from current inputs and ex_* state, valid within the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read = 0, so stall deasserts; the dependent instruction is then captured with fwd = 01.
- Simultaneous flush and stall: flush wins, stall = 0, pc/ifid enables high.
- Reset (async, any time, including mid-stall): every registered output goes to 0. This covers all ex_* fields, fwd selects 00 and stall_count 0. stall then evaluates to 0 and pc_write_en = ifid_write_en = 1.
- First posedge after rst_n rises captures normally.

## Test plan
- Reset mid-operation: drive valid traffic, assert rst_n = 0 between edges → all ex_* and stall_count read 0 immediately, stall = 0.
- Load-use: lw $8 in EX (ex_mem_read = 1, ex_dest = 8), ID add $9,$8,$4 → stall = 1, pc_write_en = 0. Next edge: ex_valid = 0, stall_count = 1. Following edge: add captured with ex_fwd_a = 01.
- Forward priority: ex_dest = 5 with ex_reg_write, mem_dest = 5 with mem_reg_write, id_rs = 5, id_rt = 5 → ex_fwd_a = ex_fwd_b = 10. Same with ex_reg_write = 0 → 01.
- Register zero: ex_dest = 0, mem_dest = 0, both writing, id_rs = 0, ex_mem_read = 1 → stall = 0, fwd = 00.
- Flush beats stall: load-use condition plus flush = 1 → stall = 0, next ex_valid = 0, stall_count unchanged.
- Saturation: force 70000 consecutive stall cycles → stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush,
// registered forwarding selects and a saturating stall-cycle counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic [3:0]  id_alu_op,
    input  logic        flush,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest,
    output logic        stall,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_alu_src,
    output logic [3:0]  ex_alu_op,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic [15:0] stall_count
);
    logic        valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q;
    logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_q, rt_q, dest_q;
    logic [3:0]  alu_op_q;
    logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Selects are computed from the producers ahead of this instruction at capture time.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        return (valid_q && reg_write_q && dest_q != 5'd0 && dest_q == r) ? 2'b10 :
               (mem_reg_write && mem_dest != 5'd0 && mem_dest == r)     ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        stall = id_valid & valid_q & mem_read_q & (dest_q != 5'd0) &
                ((dest_q == id_rs) | (id_uses_rt & (dest_q == id_rt))) & ~flush;
        pc_write_en   = ~stall;
        ifid_write_en = ~stall;
        fwd_a_d = fwd_sel(id_rs);
        fwd_b_d = fwd_sel(id_rt);
        stall_count_d = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q} <= '0;
            {pc_q, rs_data_q, rt_data_q, imm_q} <= '0;
            {rs_q, rt_q, dest_q, alu_op_q, fwd_a_q, fwd_b_q} <= '0;
            stall_count_q <= '0;
        end else begin
            if (flush || stall) begin
                {valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q} <= '0;
            end else begin
                valid_q      <= id_valid;
                reg_write_q  <= id_reg_write;
                mem_read_q   <= id_mem_read;
                mem_write_q  <= id_mem_write;
                mem_to_reg_q <= id_mem_to_reg;
                alu_src_q    <= id_alu_src;
                pc_q         <= id_pc;
                rs_data_q    <= id_rs_data;
                rt_data_q    <= id_rt_data;
                imm_q        <= id_imm;
                rs_q         <= id_rs;
                rt_q         <= id_rt;
                dest_q       <= id_reg_dst ? id_rd : id_rt;
                alu_op_q     <= id_alu_op;
                fwd_a_q      <= fwd_a_d;
                fwd_b_q      <= fwd_b_d;
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_alu_src    = alu_src_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_fwd_a      = fwd_a_q;
    assign ex_fwd_b      = fwd_b_q;
    assign stall_count   = stall_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, load-use bubble, flush, forwarding,
// register-zero handling, counter saturation and asynchronous reset.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic        id_mem_to_reg, id_alu_src, id_reg_dst, flush, mem_reg_write;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, mem_dest;
    logic [3:0]  id_alu_op;
    logic        stall, pc_write_en, ifid_write_en, ex_valid, ex_reg_write, ex_mem_read;
    logic        ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [15:0] stall_count;
    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .stall(stall),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data fields are derived from pc so captured values are distinguishable.
    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic uses_rt, input logic rw,
                          input logic mr, input logic rdst);
        id_valid = 1'b1; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rt = uses_rt; id_reg_write = rw; id_mem_read = mr; id_reg_dst = rdst;
        id_rs_data = pc ^ 32'hA5A5_0000; id_rt_data = ~pc; id_imm = pc >> 2;
        id_mem_write = 1'b0; id_mem_to_reg = mr; id_alu_src = mr;
        id_alu_op = mr ? 4'd2 : 4'd0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_reg_write = 1'b0; mem_dest = 5'd0;
        set_id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pc_write_en", pc_write_en, 1);
        #5 rst_n = 1'b1;
        // lw $8, 0x40($29)
        set_id(32'h100, 5'd29, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("lw_no_stall", stall, 0);
        step();
        chk("lw_ex_valid", ex_valid, 1);
        chk("lw_ex_pc", ex_pc, 32'h100);
        chk("lw_ex_dest", ex_dest, 8);
        chk("lw_ex_mem_read", ex_mem_read, 1);
        chk("lw_ex_rs_data", ex_rs_data, 32'hA5A5_0100);
        chk("lw_ex_rt_data", ex_rt_data, 32'hFFFF_FEFF);
        chk("lw_ex_imm", ex_imm, 32'h40);
        chk("lw_ex_alu_op", ex_alu_op, 2);
        chk("lw_ex_fwd_a", ex_fwd_a, 0);
        // add $9, $8, $4 depends on the load
        set_id(32'h104, 5'd8, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_pc_write_en", pc_write_en, 0);
        chk("lu_ifid_write_en", ifid_write_en, 0);
        step();
        chk("bubble_ex_valid", ex_valid, 0);
        chk("bubble_ex_mem_read", ex_mem_read, 0);
        chk("bubble_ex_reg_write", ex_reg_write, 0);
        chk("bubble_ex_pc_held", ex_pc, 32'h100);
        chk("bubble_stall_count", stall_count, 1);
        mem_reg_write = 1'b1; mem_dest = 5'd8;
        #1 chk("after_bubble_stall", stall, 0);
        step();
        chk("add_ex_valid", ex_valid, 1);
        chk("add_ex_pc", ex_pc, 32'h104);
        chk("add_ex_dest", ex_dest, 9);
        chk("add_fwd_a", ex_fwd_a, 2'b01);
        chk("add_fwd_b", ex_fwd_b, 2'b00);
        chk("add_stall_count", stall_count, 1);
        // producer of $5 into EX, then consumer with $5 also in MEM
        mem_reg_write = 1'b0;
        set_id(32'h108, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("prod_ex_dest", ex_dest, 5);
        mem_reg_write = 1'b1; mem_dest = 5'd5;
        set_id(32'h10C, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("prio_fwd_a", ex_fwd_a, 2'b10);
        chk("prio_fwd_b", ex_fwd_b, 2'b10);
        set_id(32'h110, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("memonly_fwd_a", ex_fwd_a, 2'b01);
        chk("memonly_fwd_b", ex_fwd_b, 2'b01);
        // writes to $0 must neither stall nor forward
        mem_dest = 5'd0;
        set_id(32'h114, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk("r0_ex_dest", ex_dest, 0);
        chk("r0_ex_mem_read", ex_mem_read, 1);
        set_id(32'h118, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("r0_stall", stall, 0);
        step();
        chk("r0_ex_valid", ex_valid, 1);
        chk("r0_fwd_a", ex_fwd_a, 0);
        chk("r0_fwd_b", ex_fwd_b, 0);
        chk("r0_stall_count", stall_count, 1);
        // flush beats a simultaneous load-use stall
        mem_reg_write = 1'b0;
        set_id(32'h11C, 5'd3, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(32'h120, 5'd8, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_stall", stall, 0);
        chk("flush_pc_write_en", pc_write_en, 1);
        step();
        flush = 1'b0;
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_ex_pc_held", ex_pc, 32'h11C);
        chk("flush_stall_count", stall_count, 1);
        // saturation: preload near the top, then three more load-use stalls
        force dut.stall_count_q = 16'hFFFD;
        #1 release dut.stall_count_q;
        chk("sat_preload", stall_count, 16'hFFFD);
        for (int i = 0; i < 3; i++) begin
            set_id(32'h200 + 32'(i * 8), 5'd3, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
            set_id(32'h204 + 32'(i * 8), 5'd8, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
            #1 chk("sat_stall", stall, 1);
            step();
            chk("sat_count", stall_count, (i == 0) ? 16'hFFFE : 16'hFFFF);
        end
        // asynchronous reset in the middle of a stall
        set_id(32'h300, 5'd3, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(32'h304, 5'd8, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ex_valid", ex_valid, 0);
        chk("mid_rst_ex_pc", ex_pc, 0);
        chk("mid_rst_ex_dest", ex_dest, 0);
        chk("mid_rst_ex_mem_read", ex_mem_read, 0);
        chk("mid_rst_fwd_a", ex_fwd_a, 0);
        chk("mid_rst_stall_count", stall_count, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_ifid_write_en", ifid_write_en, 1);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_ex_valid", ex_valid, 1);
        chk("post_rst_ex_pc", ex_pc, 32'h304);
        chk("post_rst_ex_dest", ex_dest, 9);
        chk("post_rst_stall_count", stall_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
